p_sub_share: RTL and testbench

//  Shares one p_sub datapath among NREQ requesters. Round-robin arbitration,
//  two-stage registered pipeline (operand reg -> p_sub -> result reg), valid/ready
//  on both sides. Tags results with requester id; counts flagged results.

---
 rtl/p_sub_share.sv | 212 +++++++++++++++++++++
 tb/tb_p_sub_share.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p_sub_share.sv
// p_sub_share: one p_sub subtractor shared by NREQ requesters through a
// round-robin arbiter and a two-stage pipeline (operand reg -> p_sub -> result
// reg). Results carry the requester id; results with any flag are counted.

package p_sub_share_pkg;
    typedef enum logic [1:0] {INT = 2'd0, FXP = 2'd1} dtype_e;

    typedef struct packed {
        dtype_e     kind;
        logic       sgn;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;
endpackage

// p_sub: out = in1 - in2 in O_CONF format. Operands are aligned to the finest
// fraction, subtracted exactly, then rounded half-up to the output fraction and
// saturated to the output range. ovf/udf report saturation, rounded reports
// discarded fraction bits.
module p_sub import p_sub_share_pkg::*; #(
    parameter dconf_t I1_CONF = '{INT, 1'b1, 8'd8, 8'd0},
    parameter dconf_t I2_CONF = '{INT, 1'b1, 8'd8, 8'd0},
    parameter dconf_t O_CONF  = '{INT, 1'b1, 8'd8, 8'd0}
) (
    input  logic [I1_CONF.prec-1:0] in1,
    input  logic [I2_CONF.prec-1:0] in2,
    output logic [O_CONF.prec-1:0]  out,
    output logic                    ovf,
    output logic                    udf,
    output logic                    rounded
);
    localparam int W   = 64;
    localparam int P1  = int'(I1_CONF.prec);
    localparam int P2  = int'(I2_CONF.prec);
    localparam int PO  = int'(O_CONF.prec);
    localparam int F1  = int'(I1_CONF.frac);
    localparam int F2  = int'(I2_CONF.frac);
    localparam int FO  = int'(O_CONF.frac);
    localparam int F12 = (F1 > F2) ? F1 : F2;
    localparam int F   = (F12 > FO) ? F12 : FO;
    localparam int SH1 = F - F1;
    localparam int SH2 = F - F2;
    localparam int SHO = F - FO;

    localparam logic signed [W-1:0] ONE  = 64'sd1;
    localparam logic signed [W-1:0] MASK = (ONE <<< SHO) - ONE;
    localparam logic signed [W-1:0] HALF = (ONE <<< SHO) >>> 1;
    localparam logic signed [W-1:0] OMAX = O_CONF.sgn ? ((ONE <<< (PO - 1)) - ONE)
                                                      : ((ONE <<< PO) - ONE);
    localparam logic signed [W-1:0] OMIN = O_CONF.sgn ? -(ONE <<< (PO - 1)) : '0;

    logic signed [W-1:0] a_w, b_w, diff, res_w;

    // Exact wide difference, then round and saturate into the output format.
    always_comb begin
        a_w     = {{(W-P1){I1_CONF.sgn & in1[P1-1]}}, in1};
        b_w     = {{(W-P2){I2_CONF.sgn & in2[P2-1]}}, in2};
        a_w     = a_w <<< SH1;
        b_w     = b_w <<< SH2;
        diff    = a_w - b_w;
        rounded = |(diff & MASK);
        res_w   = (diff + HALF) >>> SHO;
        ovf     = res_w > OMAX;
        udf     = res_w < OMIN;
        out     = res_w[PO-1:0];
        if (ovf) out = OMAX[PO-1:0];
        if (udf) out = OMIN[PO-1:0];
    end
endmodule

module p_sub_share import p_sub_share_pkg::*; #(
    parameter dconf_t I1_CONF = '{INT, 1'b1, 8'd8, 8'd0},
    parameter dconf_t I2_CONF = '{INT, 1'b1, 8'd8, 8'd0},
    parameter dconf_t O_CONF  = '{INT, 1'b1, 8'd8, 8'd0},
    parameter int     NREQ    = 4,
    parameter int     CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*I1_CONF.prec-1:0] req_in1,
    input  logic [NREQ*I2_CONF.prec-1:0] req_in2,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(NREQ)-1:0]      res_id,
    output logic [O_CONF.prec-1:0]       res_out,
    output logic                         res_ovf,
    output logic                         res_udf,
    output logic                         res_rnd,
    output logic [CNT_W-1:0]             err_cnt,
    input  logic                         err_clr
);
    localparam int ID_W = $clog2(NREQ);
    localparam int P1   = int'(I1_CONF.prec);
    localparam int P2   = int'(I2_CONF.prec);
    localparam int PO   = int'(O_CONF.prec);

    logic            s1_v_q;
    logic [ID_W-1:0] s1_id_q;
    logic [P1-1:0]   s1_a_q;
    logic [P2-1:0]   s1_b_q;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            res_valid_q, res_ovf_q, res_udf_q, res_rnd_q;
    logic [ID_W-1:0] res_id_q;
    logic [PO-1:0]   res_out_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic            s1_en, s2_en, gnt_any, gnt;
    logic [ID_W-1:0] gnt_id;
    logic [PO-1:0]   sub_out;
    logic            sub_ovf, sub_udf, sub_rnd, load_flag;

    assign s2_en = !res_valid_q || res_ready;
    assign s1_en = !s1_v_q || s2_en;
    assign gnt   = s1_en && gnt_any;

    // Round-robin search starting at rr_ptr; first pending requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_any   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
        if (gnt) req_ready[gnt_id] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (gnt) rr_ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    p_sub #(
        .I1_CONF (I1_CONF),
        .I2_CONF (I2_CONF),
        .O_CONF  (O_CONF)
    ) u_sub (
        .in1     (s1_a_q),
        .in2     (s1_b_q),
        .out     (sub_out),
        .ovf     (sub_ovf),
        .udf     (sub_udf),
        .rounded (sub_rnd)
    );

    assign load_flag = s2_en && s1_v_q && (sub_ovf || sub_udf || sub_rnd);

    // Flag counter: clear wins over a coincident increment; saturates at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)                             err_cnt_d = '0;
        else if (load_flag && err_cnt_q != '1)   err_cnt_d = err_cnt_q + 1'b1;
    end

    // Operand stage and arbiter pointer.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s1_v_q   <= 1'b0;
            s1_id_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (s1_en) begin
                s1_v_q <= gnt;
                if (gnt) begin
                    s1_id_q <= gnt_id;
                    s1_a_q  <= req_in1[int'(gnt_id)*P1 +: P1];
                    s1_b_q  <= req_in2[int'(gnt_id)*P2 +: P2];
                end
            end
        end
    end

    // Result stage; holds while the consumer stalls.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_out_q   <= '0;
            res_ovf_q   <= 1'b0;
            res_udf_q   <= 1'b0;
            res_rnd_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (s2_en) begin
                res_valid_q <= s1_v_q;
                if (s1_v_q) begin
                    res_id_q  <= s1_id_q;
                    res_out_q <= sub_out;
                    res_ovf_q <= sub_ovf;
                    res_udf_q <= sub_udf;
                    res_rnd_q <= sub_rnd;
                end
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_out   = res_out_q;
    assign res_ovf   = res_ovf_q;
    assign res_udf   = res_udf_q;
    assign res_rnd   = res_rnd_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_p_sub_share.sv
// Directed vectors, hand-written multi-cycle sequences and a randomized
// scoreboard run for p_sub_share (INT s8, 4 requesters). A second instance with
// a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_p_sub_share;
    import p_sub_share_pkg::*;

    logic        clk = 1'b0;
    logic        reset_;
    logic [3:0]  req_valid, req_ready, sat_req_ready;
    logic [31:0] req_in1, req_in2;
    logic        res_valid, res_ready, res_ovf, res_udf, res_rnd;
    logic        sat_res_valid, sat_res_ovf, sat_res_udf, sat_res_rnd;
    logic [1:0]  res_id, sat_res_id;
    logic [7:0]  res_out, sat_res_out;
    logic [15:0] err_cnt;
    logic [1:0]  sat_err_cnt;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    p_sub_share #(.NREQ(4), .CNT_W(16)) dut (
        .clk(clk), .reset_(reset_), .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_out(res_out), .res_ovf(res_ovf), .res_udf(res_udf),
        .res_rnd(res_rnd), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    p_sub_share #(.NREQ(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_(reset_), .req_valid(req_valid), .req_ready(sat_req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .res_valid(sat_res_valid), .res_ready(res_ready),
        .res_id(sat_res_id), .res_out(sat_res_out), .res_ovf(sat_res_ovf), .res_udf(sat_res_udf),
        .res_rnd(sat_res_rnd), .err_cnt(sat_err_cnt), .err_clr(err_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
        int d;
        logic [7:0] o;
        logic ov, un;
        d  = int'($signed(a)) - int'($signed(b));
        ov = d > 127;
        un = d < -128;
        o  = ov ? 8'h7F : (un ? 8'h80 : d[7:0]);
        return {o, ov, un, 1'b0};
    endfunction

    typedef struct {
        int         k;
        logic [7:0] a, b, out;
        logic       ovf, udf;
        int         cnt;
    } vec_t;

    vec_t vt[8];

    logic        cur_v[4];
    logic [7:0]  cur_a[4], cur_b[4];
    logic [12:0] sb[$];
    logic [12:0] exp_r;
    logic [10:0] r;
    int          flagged;
    int          grants;
    int          sat_exp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 8'd3,   8'd2,   8'd1,   1'b0, 1'b0, 0};
        vt[1] = '{1, 8'h80,  8'h01,  8'h80,  1'b0, 1'b1, 1};
        vt[2] = '{2, 8'h64,  8'h9C,  8'h7F,  1'b1, 1'b0, 2};
        vt[3] = '{3, 8'h00,  8'h00,  8'h00,  1'b0, 1'b0, 2};
        vt[4] = '{0, 8'hFF,  8'h7F,  8'h80,  1'b0, 1'b0, 2};
        vt[5] = '{1, 8'h7F,  8'hFF,  8'h7F,  1'b1, 1'b0, 3};
        vt[6] = '{2, 8'h9C,  8'h64,  8'h80,  1'b0, 1'b1, 4};
        vt[7] = '{3, 8'h80,  8'h7F,  8'h80,  1'b0, 1'b1, 5};

        reset_ = 1'b0; req_valid = '0; res_ready = 1'b0; err_clr = 1'b0;
        req_in1 = '0; req_in2 = '0;
        #5;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_fields", {res_id, res_out, res_ovf, res_udf, res_rnd}, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        @(negedge clk);
        reset_ = 1'b1;

        // single-requester vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 4'(1 << vt[i].k);
            req_in1[vt[i].k*8 +: 8] = vt[i].a;
            req_in2[vt[i].k*8 +: 8] = vt[i].b;
            res_ready = 1'b1;
            #1;
            chk("vec_ready", req_ready, 32'(1 << vt[i].k));
            chk("vec_sat_ready", sat_req_ready, 32'(1 << vt[i].k));
            @(negedge clk);
            req_valid = '0;
            chk("vec_no_early_valid", res_valid, 0);
            @(negedge clk);
            chk("vec_res", {res_valid, res_id, res_out, res_ovf, res_udf, res_rnd},
                {1'b1, 2'(vt[i].k), vt[i].out, vt[i].ovf, vt[i].udf, 1'b0});
            chk("vec_sat_res", {sat_res_valid, sat_res_id, sat_res_out, sat_res_ovf, sat_res_udf, sat_res_rnd},
                {1'b1, 2'(vt[i].k), vt[i].out, vt[i].ovf, vt[i].udf, 1'b0});
            chk("vec_err_cnt", err_cnt, vt[i].cnt);
            sat_exp = (vt[i].cnt > 3) ? 3 : vt[i].cnt;
            chk("vec_sat_err_cnt", sat_err_cnt, sat_exp);
        end

        // all four request continuously: grants rotate 0,1,2,3,...
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            req_in1[k*8 +: 8] = 8'(k*10 + 5);
            req_in2[k*8 +: 8] = 8'(k);
        end
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("rr_ready", req_ready, 32'(1 << (c % 4)));
            if (c >= 2)
                chk("rr_res", {res_valid, res_id, res_out},
                    {1'b1, 2'((c-2) % 4), 8'(9*((c-2) % 4) + 5)});
        end
        @(negedge clk); req_valid = '0;
        @(negedge clk); @(negedge clk); @(negedge clk);

        // backpressure: rr_ptr is 2 here, so grants 2 then 3, then nothing
        res_ready = 1'b0;
        req_valid = 4'hF;
        grants = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready != 0) grants++;
            if (c == 0) chk("bp_ready0", req_ready, 4'b0100);
            if (c == 1) chk("bp_ready1", req_ready, 4'b1000);
            if (c >= 2) begin
                chk("bp_ready_stall", req_ready, 0);
                chk("bp_res_hold", {res_valid, res_id, res_out}, {1'b1, 2'd2, 8'd23});
            end
        end
        chk("bp_grant_count", grants, 2);
        @(negedge clk);
        res_ready = 1'b1;
        req_valid = '0;
        #1;
        chk("bp_pop0", {res_valid, res_id, res_out}, {1'b1, 2'd2, 8'd23});
        @(negedge clk);
        chk("bp_pop1", {res_valid, res_id, res_out}, {1'b1, 2'd3, 8'd32});
        @(negedge clk);
        chk("bp_drained", res_valid, 0);

        // err_clr on the same edge as a flagged load
        @(negedge clk);
        req_valid = 4'b0001;
        req_in1[7:0] = 8'h80;
        req_in2[7:0] = 8'h01;
        @(negedge clk);
        req_valid = '0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_res", {res_valid, res_udf}, 2'b11);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_sat_err_cnt", sat_err_cnt, 0);

        // async reset in the middle of a flagged stream (rr_ptr is 1 here)
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            req_in1[k*8 +: 8] = 8'h7F;
            req_in2[k*8 +: 8] = 8'hFF;
        end
        req_valid = 4'hF;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        chk("pre_rst_err_cnt", err_cnt, 2);
        chk("pre_rst_res_valid", res_valid, 1);
        #1 reset_ = 1'b0;
        #1;
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_sat_err_cnt", sat_err_cnt, 0);
        #1 reset_ = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("post_rst_no_stale", res_valid, 0);
        @(negedge clk);
        req_valid = '0;
        chk("post_rst_first", {res_valid, res_id, res_out, res_ovf}, {1'b1, 2'd0, 8'h7F, 1'b1});
        @(negedge clk); @(negedge clk); @(negedge clk);

        // clean reset, then randomized traffic against the scoreboard
        reset_ = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        flagged = 0;
        for (int k = 0; k < 4; k++) begin
            cur_v[k] = 1'b0; cur_a[k] = '0; cur_b[k] = '0;
        end
        for (int n = 0; n < 4016; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (!cur_v[k] && n < 4000 && $urandom_range(0, 2) != 0) begin
                    cur_v[k] = 1'b1;
                    cur_a[k] = 8'($urandom);
                    cur_b[k] = 8'($urandom);
                end
                req_valid[k] = cur_v[k];
                req_in1[k*8 +: 8] = cur_a[k];
                req_in2[k*8 +: 8] = cur_b[k];
            end
            res_ready = (n < 4000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk("rand_onehot", 32'($onehot0(req_ready)), 1);
            chk("rand_ready_valid", 32'(req_ready & ~req_valid), 0);
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("rand_unexpected_res", res_valid, 0);
                end else begin
                    exp_r = sb.pop_front();
                    chk("rand_res", {res_id, res_out, res_ovf, res_udf, res_rnd}, exp_r);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (req_ready[k]) begin
                    r = ref_sub(cur_a[k], cur_b[k]);
                    sb.push_back({2'(k), r});
                    if (|r[2:0]) flagged++;
                    cur_v[k] = 1'b0;
                end
            end
        end
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_err_cnt", err_cnt, 16'(flagged));
        sat_exp = (flagged > 3) ? 3 : flagged;
        chk("rand_sat_err_cnt", sat_err_cnt, sat_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
